// File: rtl/lcd_request_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_request_scheduler
//  Description : Two-requester (CPU / debug) round-robin front end feeding a
//                small request FIFO, drained by an FSM that paces lcd_start
//                pulses so each LCD redraw completes before the next issue.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_request_scheduler #(
  parameter int DEPTH       = 4,
  parameter int HOLDOFF     = 2_100_000,
  parameter int INIT_CYCLES = 600_000
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_cpu_req,
  input  logic [2:0]               i_cpu_opcode,
  input  logic [3:0]               i_cpu_reg,
  input  logic [15:0]              i_cpu_value,
  output logic                     o_cpu_ack,
  input  logic                     i_dbg_req,
  input  logic [2:0]               i_dbg_opcode,
  input  logic [3:0]               i_dbg_reg,
  input  logic [15:0]              i_dbg_value,
  output logic                     o_dbg_ack,
  output logic                     o_lcd_start,
  output logic [2:0]               o_lcd_opcode,
  output logic [3:0]               o_lcd_reg_idx,
  output logic [15:0]              o_lcd_value,
  output logic                     o_busy,
  output logic [$clog2(DEPTH):0]   o_fifo_count
);

  localparam int c_PTR_W   = $clog2(DEPTH);
  localparam int c_CNT_MAX = (HOLDOFF > INIT_CYCLES) ? HOLDOFF : INIT_CYCLES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_INIT_LOAD = c_CNT_W'(INIT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_HOLD_LOAD = c_CNT_W'(HOLDOFF - 1);
  localparam logic [c_PTR_W:0]   c_DEPTH     = (c_PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_WAIT_INIT = 2'd0,
    S_IDLE      = 2'd1,
    S_ISSUE     = 2'd2,
    S_HOLD      = 2'd3
  } state_t;

  // FIFO storage: {opcode[22:20], reg[19:16], value[15:0]}
  logic [22:0]          r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_wptr;
  logic [c_PTR_W-1:0]   r_rptr;
  logic [c_PTR_W:0]     r_count;
  logic                 r_last_dbg;   // 1: debug was granted last, so CPU wins a tie

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_lcd_start;
  logic [2:0]           r_lcd_opcode;
  logic [3:0]           r_lcd_reg_idx;
  logic [15:0]          r_lcd_value;

  logic                 w_can_enq;
  logic                 w_cpu_win;
  logic                 w_dbg_win;
  logic                 w_enq;
  logic                 w_deq;
  logic [22:0]          w_wdata;

  // Arbitration: a lone requester wins; on a tie, the side not granted last wins
  assign w_can_enq = (r_count != c_DEPTH);
  assign w_cpu_win = i_cpu_req & (~i_dbg_req | r_last_dbg);
  assign w_dbg_win = i_dbg_req & ~w_cpu_win;
  assign w_enq     = w_can_enq & (w_cpu_win | w_dbg_win);
  assign w_deq     = (r_state == S_IDLE) & (r_count != '0);
  assign w_wdata   = w_cpu_win ? {i_cpu_opcode, i_cpu_reg, i_cpu_value}
                               : {i_dbg_opcode, i_dbg_reg, i_dbg_value};

  // Acks are same-cycle and forced low while reset is asserted
  assign o_cpu_ack = w_can_enq & w_cpu_win & ~i_reset;
  assign o_dbg_ack = w_can_enq & w_dbg_win & ~i_reset;

  assign o_busy        = (r_state != S_IDLE) | (r_count != '0);
  assign o_fifo_count  = r_count;
  assign o_lcd_start   = r_lcd_start;
  assign o_lcd_opcode  = r_lcd_opcode;
  assign o_lcd_reg_idx = r_lcd_reg_idx;
  assign o_lcd_value   = r_lcd_value;

  // FIFO payload write; contents need no reset since pointers define validity
  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_mem[r_wptr] <= w_wdata;
    end
  end

  // FIFO pointers, occupancy and round-robin history
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_last_dbg <= 1'b1;
    end else begin
      if (w_enq) begin
        r_wptr     <= r_wptr + 1'b1;
        r_last_dbg <= w_dbg_win;
      end
      if (w_deq) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue pacing FSM: init wait, pop, one-cycle start pulse, redraw hold-off
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_WAIT_INIT;
      r_cnt         <= c_INIT_LOAD;
      r_lcd_start   <= 1'b0;
      r_lcd_opcode  <= '0;
      r_lcd_reg_idx <= '0;
      r_lcd_value   <= '0;
    end else begin
      r_lcd_start <= 1'b0;
      case (r_state)
        S_WAIT_INIT: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_IDLE: begin
          if (r_count != '0) begin
            {r_lcd_opcode, r_lcd_reg_idx, r_lcd_value} <= r_mem[r_rptr];
            r_lcd_start <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= c_HOLD_LOAD;
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_WAIT_INIT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_request_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_request_scheduler
//  Description : Self-checking bench for lcd_request_scheduler. A queue-based
//                reference model predicts acks, occupancy, busy and issue
//                timing from the earliest-next-issue cycle arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_request_scheduler;

  localparam int DEPTH       = 4;
  localparam int HOLDOFF     = 8;
  localparam int INIT_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, dbg_req;
  logic [2:0]  cpu_op, dbg_op;
  logic [3:0]  cpu_reg, dbg_reg;
  logic [15:0] cpu_val, dbg_val;
  logic        cpu_ack, dbg_ack;
  logic        lcd_start;
  logic [2:0]  lcd_op;
  logic [3:0]  lcd_reg;
  logic [15:0] lcd_val;
  logic        busy;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  lcd_request_scheduler #(
    .DEPTH(DEPTH), .HOLDOFF(HOLDOFF), .INIT_CYCLES(INIT_CYCLES)
  ) dut (
    .i_clk(clk), .i_reset(rst),
    .i_cpu_req(cpu_req), .i_cpu_opcode(cpu_op), .i_cpu_reg(cpu_reg),
    .i_cpu_value(cpu_val), .o_cpu_ack(cpu_ack),
    .i_dbg_req(dbg_req), .i_dbg_opcode(dbg_op), .i_dbg_reg(dbg_reg),
    .i_dbg_value(dbg_val), .o_dbg_ack(dbg_ack),
    .o_lcd_start(lcd_start), .o_lcd_opcode(lcd_op), .o_lcd_reg_idx(lcd_reg),
    .o_lcd_value(lcd_val), .o_busy(busy), .o_fifo_count(fifo_count)
  );

  int n_vec = 0;
  int n_err = 0;

  // Requester scripts: each side keeps requesting its head entry until acked
  logic [22:0] cpu_todo[$];
  logic [22:0] dbg_todo[$];
  logic [22:0] seen_issue[$];

  // Reference model: queue contents plus the earliest cycle the next pop may occur
  int          cyc;
  int          ready;
  logic [22:0] mq[$];
  bit          m_last_dbg;
  bit          m_pop_prev;
  logic [22:0] m_issued;

  // Per-cycle expectations and observations
  bit          e_cpu_ack, e_dbg_ack, e_start, e_busy, e_pop;
  int          e_count;
  logic [22:0] e_payload;
  bit          obs_cpu_ack, obs_dbg_ack, obs_start, obs_busy;
  int          obs_count;
  logic [22:0] obs_payload;

  function automatic void model_reset();
    cyc        = 0;
    ready      = INIT_CYCLES;
    mq.delete();
    m_last_dbg = 1'b1;
    m_pop_prev = 1'b0;
    m_issued   = '0;
    cpu_todo.delete();
    dbg_todo.delete();
    seen_issue.delete();
  endfunction

  // One clock cycle: entered and left at posedge+1
  task automatic step();
    bit can_enq, cw, dw;
    if (cpu_todo.size() > 0) begin
      cpu_req = 1'b1; {cpu_op, cpu_reg, cpu_val} = cpu_todo[0];
    end else begin
      cpu_req = 1'b0; {cpu_op, cpu_reg, cpu_val} = 23'd0;
    end
    if (dbg_todo.size() > 0) begin
      dbg_req = 1'b1; {dbg_op, dbg_reg, dbg_val} = dbg_todo[0];
    end else begin
      dbg_req = 1'b0; {dbg_op, dbg_reg, dbg_val} = 23'd0;
    end
    e_count   = mq.size();
    e_busy    = (cyc < ready) || (mq.size() != 0);
    e_start   = m_pop_prev;
    e_payload = m_issued;
    e_pop     = (cyc >= ready) && (mq.size() != 0);
    can_enq   = mq.size() < DEPTH;
    cw        = cpu_req && (!dbg_req || m_last_dbg);
    dw        = dbg_req && !cw;
    e_cpu_ack = can_enq && cw;
    e_dbg_ack = can_enq && dw;
    @(negedge clk);
    obs_cpu_ack = cpu_ack;
    obs_dbg_ack = dbg_ack;
    obs_start   = lcd_start;
    obs_busy    = busy;
    obs_count   = int'(fifo_count);
    obs_payload = {lcd_op, lcd_reg, lcd_val};
    if (obs_start) seen_issue.push_back(obs_payload);
    if (e_pop) begin
      m_issued = mq.pop_front();
      ready    = cyc + HOLDOFF + 2;
    end
    m_pop_prev = e_pop;
    if (e_cpu_ack) begin
      mq.push_back(cpu_todo.pop_front());
      m_last_dbg = 1'b0;
    end else if (e_dbg_ack) begin
      mq.push_back(dbg_todo.pop_front());
      m_last_dbg = 1'b1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic restart();
    rst = 1'b1;
    #1;
    release_reset();
  endtask

  task automatic test_reset();
    cpu_req = 1'b1; dbg_req = 1'b1;
    {cpu_op, cpu_reg, cpu_val} = 23'h5A5A5;
    {dbg_op, dbg_reg, dbg_val} = 23'h12345;
    #12;
    n_vec++; if (lcd_start !== 1'b0) begin n_err++; $display("FAIL rst_start got=%b exp=0", lcd_start); end
    n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL rst_count got=%0d exp=0", fifo_count); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_busy got=%b exp=1", busy); end
    n_vec++; if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL rst_cpu_ack got=%b exp=0", cpu_ack); end
    n_vec++; if (dbg_ack !== 1'b0) begin n_err++; $display("FAIL rst_dbg_ack got=%b exp=0", dbg_ack); end
    n_vec++; if ({lcd_op, lcd_reg, lcd_val} !== 23'd0) begin n_err++; $display("FAIL rst_payload got=%h exp=0", {lcd_op, lcd_reg, lcd_val}); end
    cpu_req = 1'b0; dbg_req = 1'b0;
    release_reset();
  endtask

  task automatic test_first_issue();
    logic [15:0] v;
    int start_cyc;
    v = -16'sd5;
    step();
    cpu_todo.push_back({3'd2, 4'b0010, v});
    step();
    n_vec++; if (obs_cpu_ack !== 1'b1) begin n_err++; $display("FAIL first_ack cyc=1 got=%b exp=1", obs_cpu_ack); end
    start_cyc = -1;
    for (int k = 0; k < 20 && start_cyc < 0; k++) begin
      step();
      n_vec++; if (obs_start !== e_start) begin n_err++; $display("FAIL first_start cyc=%0d got=%b exp=%b", cyc - 1, obs_start, e_start); end
      if (obs_start) start_cyc = cyc - 1;
    end
    n_vec++; if (start_cyc != INIT_CYCLES + 1) begin n_err++; $display("FAIL first_start_cycle got=%0d exp=%0d", start_cyc, INIT_CYCLES + 1); end
    n_vec++; if (lcd_val !== 16'hFFFB) begin n_err++; $display("FAIL first_value got=%h exp=fffb", lcd_val); end
    n_vec++; if (lcd_op !== 3'd2 || lcd_reg !== 4'b0010) begin n_err++; $display("FAIL first_op_reg got=%0d/%0d exp=2/2", lcd_op, lcd_reg); end
  endtask

  task automatic test_round_robin();
    logic [22:0] c_ent, d_ent;
    int s0, s1;
    restart();
    for (int k = 0; k < INIT_CYCLES; k++) step();
    c_ent = {3'd1, 4'd3, 16'h1111};
    d_ent = {3'd6, 4'd9, 16'h8001};
    cpu_todo.push_back(c_ent);
    dbg_todo.push_back(d_ent);
    step();
    n_vec++; if (obs_cpu_ack !== 1'b1 || obs_dbg_ack !== 1'b0) begin n_err++; $display("FAIL rr_first got=%b%b exp=10", obs_cpu_ack, obs_dbg_ack); end
    step();
    n_vec++; if (obs_cpu_ack !== 1'b0 || obs_dbg_ack !== 1'b1) begin n_err++; $display("FAIL rr_second got=%b%b exp=01", obs_cpu_ack, obs_dbg_ack); end
    s0 = -1; s1 = -1;
    for (int k = 0; k < 40 && s1 < 0; k++) begin
      step();
      n_vec++; if (obs_start !== e_start) begin n_err++; $display("FAIL rr_start cyc=%0d got=%b exp=%b", cyc - 1, obs_start, e_start); end
      if (obs_start) begin
        if (s0 < 0) s0 = cyc - 1; else s1 = cyc - 1;
      end
    end
    n_vec++; if (s1 - s0 != HOLDOFF + 2 || s0 < 0) begin n_err++; $display("FAIL rr_spacing got=%0d exp=%0d", s1 - s0, HOLDOFF + 2); end
    n_vec++; if (seen_issue.size() != 2) begin n_err++; $display("FAIL rr_issue_count got=%0d exp=2", seen_issue.size()); end
    else begin
      n_vec++; if (seen_issue[0] !== c_ent || seen_issue[1] !== d_ent) begin n_err++; $display("FAIL rr_order got=%h,%h exp=%h,%h", seen_issue[0], seen_issue[1], c_ent, d_ent); end
    end
  endtask

  task automatic test_backpressure();
    logic [22:0] b[6];
    int max_cnt, phase;
    bit hit;
    restart();
    for (int k = 0; k < INIT_CYCLES; k++) step();
    cpu_todo.push_back({3'd7, 4'd15, 16'hAAAA});
    for (int k = 0; k < 20 && seen_issue.size() == 0; k++) step();
    for (int i = 0; i < 6; i++) begin
      b[i] = {3'(i), 4'(i + 8), 16'(16'h0100 * (i + 1) + 16'h0055)};
      cpu_todo.push_back(b[i]);
    end
    max_cnt = 0; phase = 0; hit = 1'b0;
    for (int k = 0; k < 150 && seen_issue.size() < 7; k++) begin
      step();
      n_vec++; if (obs_count !== e_count) begin n_err++; $display("FAIL bp_count cyc=%0d got=%0d exp=%0d", cyc - 1, obs_count, e_count); end
      n_vec++; if (obs_cpu_ack !== e_cpu_ack) begin n_err++; $display("FAIL bp_ack cyc=%0d got=%b exp=%b", cyc - 1, obs_cpu_ack, e_cpu_ack); end
      if (obs_count > max_cnt) max_cnt = obs_count;
      if (phase == 2) begin
        n_vec++; if (obs_count != DEPTH) begin n_err++; $display("FAIL bp_refill got=%0d exp=%0d", obs_count, DEPTH); end
        phase = 3;
      end
      if (phase == 1) begin
        n_vec++; if (obs_cpu_ack !== 1'b1) begin n_err++; $display("FAIL bp_after_pop_ack got=%b exp=1", obs_cpu_ack); end
        phase = 2;
      end
      if (phase == 0 && e_pop && e_count == DEPTH && cpu_req) begin
        n_vec++; if (obs_cpu_ack !== 1'b0) begin n_err++; $display("FAIL bp_pop_cycle_ack got=%b exp=0", obs_cpu_ack); end
        phase = 1; hit = 1'b1;
      end
    end
    n_vec++; if (!hit) begin n_err++; $display("FAIL bp_full_pop_seen got=0 exp=1"); end
    n_vec++; if (max_cnt != DEPTH) begin n_err++; $display("FAIL bp_max_count got=%0d exp=%0d", max_cnt, DEPTH); end
    n_vec++; if (seen_issue.size() != 7) begin n_err++; $display("FAIL bp_issued got=%0d exp=7", seen_issue.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        n_vec++; if (seen_issue[i + 1] !== b[i]) begin n_err++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i, seen_issue[i + 1], b[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [22:0] e_ent;
    bit found;
    int start_cyc;
    restart();
    for (int k = 0; k < INIT_CYCLES; k++) step();
    for (int i = 0; i < 4; i++) cpu_todo.push_back({3'd3, 4'(i), 16'(16'h7000 + i)});
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      if (mq.size() == 3 && cpu_todo.size() == 0 && cyc < ready && !m_pop_prev && cyc > INIT_CYCLES)
        found = 1'b1;
      else
        step();
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL mid_setup got=0 exp=1"); end
    n_vec++; if (fifo_count !== 3'd3) begin n_err++; $display("FAIL mid_pre_count got=%0d exp=3", fifo_count); end
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL mid_count got=%0d exp=0", fifo_count); end
    n_vec++; if (lcd_start !== 1'b0) begin n_err++; $display("FAIL mid_start got=%b exp=0", lcd_start); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy got=%b exp=1", busy); end
    release_reset();
    e_ent = {3'd5, 4'd1, 16'hC0DE};
    cpu_todo.push_back(e_ent);
    start_cyc = -1;
    for (int k = 0; k < 20 && start_cyc < 0; k++) begin
      step();
      if (k == 0) begin
        n_vec++; if (obs_cpu_ack !== 1'b1) begin n_err++; $display("FAIL mid_init_ack got=%b exp=1", obs_cpu_ack); end
      end
      n_vec++; if (obs_start !== e_start) begin n_err++; $display("FAIL mid_start_seq cyc=%0d got=%b exp=%b", cyc - 1, obs_start, e_start); end
      if (obs_start) start_cyc = cyc - 1;
    end
    n_vec++; if (start_cyc != INIT_CYCLES + 1) begin n_err++; $display("FAIL mid_first_start got=%0d exp=%0d", start_cyc, INIT_CYCLES + 1); end
    n_vec++; if ({lcd_op, lcd_reg, lcd_val} !== e_ent) begin n_err++; $display("FAIL mid_payload got=%h exp=%h", {lcd_op, lcd_reg, lcd_val}, e_ent); end
  endtask

  task automatic test_random();
    int n_enq;
    restart();
    n_enq = 0;
    for (int k = 0; k < 700; k++) begin
      if (k < 550) begin
        if (cpu_todo.size() < 3 && $urandom_range(0, 11) == 0) cpu_todo.push_back(23'($urandom));
        if (dbg_todo.size() < 3 && $urandom_range(0, 11) == 0) dbg_todo.push_back(23'($urandom));
      end
      step();
      if (e_cpu_ack || e_dbg_ack) n_enq++;
      n_vec++; if (obs_cpu_ack !== e_cpu_ack) begin n_err++; $display("FAIL rnd_cpu_ack cyc=%0d got=%b exp=%b", cyc - 1, obs_cpu_ack, e_cpu_ack); end
      n_vec++; if (obs_dbg_ack !== e_dbg_ack) begin n_err++; $display("FAIL rnd_dbg_ack cyc=%0d got=%b exp=%b", cyc - 1, obs_dbg_ack, e_dbg_ack); end
      n_vec++; if (obs_count !== e_count) begin n_err++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc - 1, obs_count, e_count); end
      n_vec++; if (obs_busy !== e_busy) begin n_err++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc - 1, obs_busy, e_busy); end
      n_vec++; if (obs_start !== e_start) begin n_err++; $display("FAIL rnd_start cyc=%0d got=%b exp=%b", cyc - 1, obs_start, e_start); end
      n_vec++; if (obs_payload !== e_payload) begin n_err++; $display("FAIL rnd_payload cyc=%0d got=%h exp=%h", cyc - 1, obs_payload, e_payload); end
    end
    n_vec++; if (seen_issue.size() != n_enq || mq.size() != 0) begin n_err++; $display("FAIL rnd_drain got=%0d exp=%0d", seen_issue.size(), n_enq); end
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; dbg_req = 1'b0;
    {cpu_op, cpu_reg, cpu_val} = 23'd0;
    {dbg_op, dbg_reg, dbg_val} = 23'd0;
    test_reset();
    test_first_issue();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lcd_request_scheduler.md
LCD_REQUEST_SCHEDULER -- requirements
Module: lcd_request_scheduler

Interface
REQ-001 Parameter DEPTH, default 4: request FIFO depth; power of two, 2..16.
REQ-002 Parameter HOLDOFF, default 2_100_000: cycles lcd_start is withheld after each issue, covering a full LCD redraw at 50 MHz.
REQ-003 Parameter INIT_CYCLES, default 600_000: cycles after reset before the first issue, covering LCD init.
REQ-004 One clock; reset is asynchronous and active-high: clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 cpu_req  in  1  CPU display request; level, held until cpu_ack.
REQ-007 cpu_opcode/cpu_reg/cpu_value  in  3/4/16  CPU payload; value is signed.
REQ-008 cpu_ack  out  1  one-cycle pulse; CPU entry accepted this cycle.
REQ-009 dbg_req, dbg_opcode, dbg_reg, dbg_value, dbg_ack: debug requester, same widths and rules as CPU.
REQ-010 lcd_start  out  1  one-cycle start pulse to the LCD controller.
REQ-011 lcd_opcode/lcd_reg_idx/lcd_value  out  3/4/16  registered payload to the LCD controller.
REQ-012 busy  out  1  high when state != IDLE or the FIFO is not empty.
REQ-013 fifo_count  out  $clog2(DEPTH)+1  number of queued entries.

Function
REQ-014 FIFO stores {opcode, reg, value} (23 bits); circular read/write pointers wrap at DEPTH.
REQ-015 At most one enqueue per cycle; enqueue is allowed only when fifo_count < DEPTH.
REQ-016 Full FIFO: no ack is given and requests stay pending (backpressure); no entry is dropped.
REQ-017 Only one requester: its entry is accepted if allowed, and its ack is high that same cycle.
REQ-018 Both requesting: round-robin. Grant goes to the requester not granted last; after reset, CPU wins first.
REQ-019 The last-grant pointer updates only on an actual enqueue.
REQ-020 Simultaneous enqueue and dequeue: fifo_count is unchanged and both operations complete.
REQ-021 FSM has 4 states: WAIT_INIT, IDLE, ISSUE, HOLD.
REQ-022 WAIT_INIT: counts INIT_CYCLES cycles, then goes to IDLE. Enqueue is permitted during WAIT_INIT.
REQ-023 IDLE with fifo_count > 0: pop the head, register it into the lcd_* payload, and go to ISSUE.
REQ-024 IDLE with an empty FIFO: stay in IDLE.
REQ-025 ISSUE lasts exactly 1 cycle: lcd_start = 1, load the hold counter with HOLDOFF-1, go to HOLD.
REQ-026 HOLD: decrement the counter each cycle; at 0, go to IDLE.
REQ-027 Issue spacing: consecutive lcd_start pulses are exactly HOLDOFF+2 cycles apart.
REQ-028 lcd_opcode/lcd_reg_idx/lcd_value stay stable from the ISSUE cycle until the next pop.
REQ-029 Latency: entry enqueued in cycle N, FIFO empty, FSM in IDLE -> lcd_start high in cycle N+2.
REQ-030 Order: entries issue in FIFO order; the payload bits pass through unmodified.
REQ-031 lcd_start is never high outside ISSUE.

Reset
REQ-032 Reset takes effect asynchronously. It clears all of the following immediately:
  - lcd_start = 0, cpu_ack = 0, dbg_ack = 0
  - lcd_opcode = 0, lcd_reg_idx = 0, lcd_value = 0
  - pointers = 0, fifo_count = 0
  - last-grant = DBG, so CPU wins next
  - state = WAIT_INIT, counter loaded with INIT_CYCLES-1
REQ-033 busy reads 1 during reset and WAIT_INIT.
REQ-034 Reset mid-operation (HOLD or non-empty FIFO): all queued entries are discarded, and no lcd_start follows until INIT_CYCLES have elapsed after release.

Verification (INIT_CYCLES=4, HOLDOFF=8, DEPTH=4)
REQ-035 Release reset; CPU request {op=2, reg=4'b0010, value=-5} at cycle 1.
  - Required: cpu_ack at cycle 1.
  - Required: no lcd_start before WAIT_INIT ends.
  - Required: then one lcd_start carrying lcd_value = 16'hFFFB, lcd_opcode = 2.
REQ-036 In IDLE, cpu_req and dbg_req asserted together and held.
  - Required: CPU acked first, DBG the next cycle.
  - Required: lcd_start pulses are 10 cycles apart, with payloads in CPU, DBG order.
REQ-037 Hold cpu_req with 6 distinct values while the FSM is in HOLD.
  - Required: fifo_count saturates at 4 and cpu_ack stays low while full.
  - Required: all 6 values eventually issue, in order, none lost.
REQ-038 FIFO full during the IDLE->ISSUE pop cycle with a pending request.
  - Required: that request is not acked in the pop cycle.
  - Required: it is acked the next cycle, and fifo_count returns to 4.
REQ-039 Assert reset during HOLD with 3 entries queued.
  - Required: fifo_count = 0 and lcd_start = 0 immediately.
  - Required: the first new lcd_start comes only after WAIT_INIT completes again.
